// File: rtl/cdc_sync_bank.sv
// Multi-channel level synchroniser: per-channel flop chain, optional stability
// filter, registered edge pulses and a shared saturating glitch counter.
module cdc_sync_bank #(
    parameter int unsigned          CHANNELS      = 8,
    parameter int unsigned          SYNC_STAGES   = 2,
    parameter int unsigned          FILTER_CYCLES = 0,
    parameter logic [CHANNELS-1:0]  RESET_LEVEL   = '0
) (
    input  logic                clk,
    input  logic                rst_n_i,
    input  logic [CHANNELS-1:0] async_i,
    input  logic                clr_glitch_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                any_change_o,
    output logic [15:0]         glitch_cnt_o
);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  s_out;
    logic [CHANNELS-1:0]                  level_next;
    logic                                 reject_any;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign s_out = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign level_next = s_out;
            assign reject_any = 1'b0;
        end else begin : g_filter
            localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
            logic [CHANNELS-1:0] reject;

            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                logic [CW-1:0] cnt_q;

                // A stable cycle that ends a non-zero run is a rejected glitch.
                always_comb begin
                    level_next[c] = level_o[c];
                    reject[c]     = 1'b0;
                    if (s_out[c] == level_o[c]) begin
                        reject[c] = (cnt_q != '0);
                    end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                        level_next[c] = s_out[c];
                    end
                end

                always_ff @(posedge clk or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        cnt_q <= '0;
                    end else if (s_out[c] == level_o[c]) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign reject_any = |reject;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_o      <= RESET_LEVEL;
            rise_o       <= '0;
            fall_o       <= '0;
            any_change_o <= 1'b0;
        end else begin
            level_o      <= level_next;
            rise_o       <= level_next & ~level_o;
            fall_o       <= ~level_next & level_o;
            any_change_o <= |(level_next ^ level_o);
        end
    end

    // Without a filter reject_any is tied low, so the counter holds zero.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            glitch_cnt_o <= '0;
        end else if (clr_glitch_i) begin
            glitch_cnt_o <= '0;
        end else if (reject_any && (glitch_cnt_o != '1)) begin
            glitch_cnt_o <= glitch_cnt_o + 16'd1;
        end
    end

endmodule
